icache_ro: RTL and testbench

Read-only, direct-mapped instruction cache that sits between the fetch stage and the instruction memory. It answers the fetch stage's word-address reads (`proc_read`/`proc_addr`) with a 32-bit instruction word, and raises `proc_stall` while it refills a missing line. Refills are 128-bit line reads from memory using a `mem_read`/`mem_ready` handshake. The fetch stage feeds `proc_stall` to its `memory_stall` input and does its own byte swapping, so words are returned exactly as memory stores them.

---
 rtl/icache_ro.sv | 140 ++++++++++++++
 tb/tb_icache_ro.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache with 128-bit line refills over a mem_read/mem_ready handshake.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache_ro #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic [29:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IDX   = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t              state_reg, state_next;
  logic                mem_read_reg, mem_read_next;
  logic [27:0]         mem_addr_reg, mem_addr_next;

  logic [NUM_BLOCKS-1:0] valid_reg;
  logic [TAG_W-1:0]    tag_mem  [NUM_BLOCKS];
  logic [127:0]        data_mem [NUM_BLOCKS];

  logic [IDX-1:0]      idx;
  logic [TAG_W-1:0]    req_tag;
  logic [127:0]        line;
  logic                hit;
  logic                fill_en;
  logic [IDX-1:0]      fill_idx;

  assign idx      = proc_addr[IDX+1:2];
  assign req_tag  = proc_addr[29:IDX+2];
  assign line     = data_mem[idx];
  assign hit      = proc_read & valid_reg[idx] & (tag_mem[idx] == req_tag);
  // A reset arriving together with mem_ready abandons the refill, so the fill is gated by rst_n.
  assign fill_en  = (state_reg == REFILL) & mem_ready & rst_n;
  assign fill_idx = mem_addr_reg[IDX-1:0];

  assign mem_read = mem_read_reg;
  assign mem_addr = mem_addr_reg;

  always_comb begin
    state_next    = state_reg;
    mem_read_next = mem_read_reg;
    mem_addr_next = mem_addr_reg;
    proc_stall    = 1'b0;
    proc_rdata    = 32'h0;
    case (state_reg)
      IDLE: begin
        if (proc_read && !hit) begin
          proc_stall    = 1'b1;
          state_next    = REFILL;
          mem_read_next = 1'b1;
          mem_addr_next = proc_addr[29:2];
        end else if (hit) begin
          proc_rdata = line[{proc_addr[1:0], 5'd0} +: 32];
        end
      end
      REFILL: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_next    = IDLE;
          mem_read_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mem_read_reg <= 1'b0;
      mem_addr_reg <= 28'h0;
    end else begin
      state_reg    <= state_next;
      mem_read_reg <= mem_read_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_en && (fill_idx == IDX'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage are intentionally left unreset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[fill_idx] <= mem_rdata;
      tag_mem[fill_idx]  <= mem_addr_reg[27:IDX];
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg  <= 32'h0;
      miss_cnt_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && hit) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (state_reg == IDLE && state_next == REFILL) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_ro.sv
// Self-checking bench for icache_ro: directed scenarios plus a randomized run against a line-residency model.
// Memory is modelled as a lazily populated map of random 128-bit lines.
module tb_icache_ro;

  localparam int NB = 8;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] mem_lines [logic [27:0]];
  bit           res_valid [NB];
  logic [27:0]  res_line  [NB];

  icache_ro #(.NUM_BLOCKS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [27:0] a);
    if (!mem_lines.exists(a)) mem_lines[a] = {$urandom, $urandom, $urandom, $urandom};
    return mem_lines[a];
  endfunction

  function automatic logic [31:0] word_of(input logic [29:0] addr);
    logic [127:0] l;
    l = line_of(addr[29:2]);
    return l[32*addr[1:0] +: 32];
  endfunction

  function automatic bit model_hit(input logic [29:0] addr);
    int i;
    i = int'(addr[29:2]) % NB;
    return res_valid[i] && (res_line[i] == addr[29:2]);
  endfunction

  function automatic void model_fill(input logic [29:0] addr);
    int i;
    i = int'(addr[29:2]) % NB;
    res_valid[i] = 1'b1;
    res_line[i]  = addr[29:2];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) res_valid[i] = 1'b0;
  endfunction

  // One fetch: holds addr until the cache stops stalling; memory answers L cycles after mem_read rises.
  task automatic fetch(input logic [29:0] addr, input int lat, output logic [31:0] data,
                       output int stalls, output int rise_at, output logic [27:0] maddr,
                       output bit mread_any);
    int rc;
    int cyc;
    stalls = 0; rise_at = -1; maddr = '0; rc = 0; cyc = 0; data = '0; mread_any = 0;
    @(negedge clk);
    proc_addr = addr; proc_read = 1'b1; mem_ready = 1'b0;
    forever begin
      #1;
      if (mem_read) mread_any = 1;
      if (!proc_stall) begin
        data = proc_rdata;
        break;
      end
      stalls++;
      if (mem_read) begin
        if (rise_at < 0) begin
          rise_at = cyc;
          maddr   = mem_addr;
        end
        if (rc == lat) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(mem_addr);
        end
        rc++;
      end
      if (cyc > 300) begin
        total++; bad++;
        $display("FAIL fetch_timeout addr=%h got stall still high want release", addr);
        break;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      cyc++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b1; proc_addr = 30'h10; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
    total++; if (mem_addr !== 28'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL reset_cold_stall got=%b want=1", proc_stall); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", proc_rdata); end
    @(negedge clk);
    proc_read = 1'b0; rst_n = 1'b1;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL idle_no_read_stall got=%b want=0", proc_stall); end
    model_clear();
    $display("reset: stall=%b mem_read=%b", proc_stall, mem_read);
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    fetch(30'h10, 3, d, st, ra, ma, mr);
    model_fill(30'h10);
    total++; if (ra !== 1) begin bad++; $display("FAIL cold_mem_read_rise got=%0d want=1", ra); end
    total++; if (ma !== 28'h4) begin bad++; $display("FAIL cold_mem_addr got=%h want=4", ma); end
    total++; if (st !== 5) begin bad++; $display("FAIL cold_stall got=%0d want=5", st); end
    total++; if (d !== 32'hAAAA_AAAA) begin bad++; $display("FAIL cold_data got=%h want=aaaaaaaa", d); end
    $display("cold miss: addr=010 stalls=%0d data=%h", st, d);
  endtask

  task automatic test_hit_sweep();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    for (int w = 0; w < 4; w++) begin
      fetch(30'h10 + 30'(w), 0, d, st, ra, ma, mr);
      total++; if (st !== 0) begin bad++; $display("FAIL sweep_stall w=%0d got=%0d want=0", w, st); end
      total++; if (d !== word_of(30'h10 + 30'(w))) begin bad++; $display("FAIL sweep_data w=%0d got=%h want=%h", w, d, word_of(30'h10 + 30'(w))); end
      total++; if (mr !== 1'b0) begin bad++; $display("FAIL sweep_mem_read w=%0d got=%b want=0", w, mr); end
      $display("hit sweep: addr=%h data=%h", 30'h10 + 30'(w), d);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    logic [29:0] seq [3];
    seq[0] = 30'h30; seq[1] = 30'h10; seq[2] = 30'h32;
    for (int k = 0; k < 3; k++) begin
      fetch(seq[k], 2, d, st, ra, ma, mr);
      model_fill(seq[k]);
      total++; if (st !== 4) begin bad++; $display("FAIL conflict_stall k=%0d got=%0d want=4", k, st); end
      total++; if (d !== word_of(seq[k])) begin bad++; $display("FAIL conflict_data k=%0d got=%h want=%h", k, d, word_of(seq[k])); end
      $display("conflict: addr=%h stalls=%0d data=%h", seq[k], st, d);
    end
  endtask

  task automatic test_latency();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    fetch(30'h10, 1, d, st, ra, ma, mr);
    model_fill(30'h10);
    total++; if (st !== 3) begin bad++; $display("FAIL lat1_stall got=%0d want=3", st); end
    fetch(30'h31, 10, d, st, ra, ma, mr);
    model_fill(30'h31);
    total++; if (st !== 12) begin bad++; $display("FAIL lat10_stall got=%0d want=12", st); end
    total++; if (d !== word_of(30'h31)) begin bad++; $display("FAIL lat10_data got=%h want=%h", d, word_of(30'h31)); end
    $display("latency: L=10 stalls=%0d", st);
  endtask

  task automatic test_spurious_ready();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    logic [127:0] l;
    @(negedge clk);
    proc_read = 1'b0; mem_ready = 1'b1;
    l = line_of(28'hC);
    mem_rdata = ~l;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL spurious_stall got=%b want=0", proc_stall); end
    @(negedge clk);
    mem_ready = 1'b0;
    fetch(30'h33, 0, d, st, ra, ma, mr);
    total++; if (st !== 0) begin bad++; $display("FAIL spurious_hit_stall got=%0d want=0", st); end
    total++; if (d !== word_of(30'h33)) begin bad++; $display("FAIL spurious_data got=%h want=%h", d, word_of(30'h33)); end
    $display("spurious ready: addr=033 data=%h", d);
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    @(negedge clk);
    proc_addr = 30'h50; proc_read = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL midrst_refill_active got=%b want=1", mem_read); end
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b0; mem_ready = 1'b1; mem_rdata = line_of(28'h14);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL midrst_mem_read got=%b want=0", mem_read); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL midrst_idle got stall=%b want=0", proc_stall); end
    model_clear();
    fetch(30'h50, 2, d, st, ra, ma, mr);
    model_fill(30'h50);
    total++; if (st !== 4) begin bad++; $display("FAIL midrst_remiss got=%0d want=4", st); end
    total++; if (d !== word_of(30'h50)) begin bad++; $display("FAIL midrst_data got=%h want=%h", d, word_of(30'h50)); end
    $display("reset mid-refill: re-request stalls=%0d data=%h", st, d);
  endtask

  task automatic test_random();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    logic [29:0] a; int lat; bit h;
    for (int n = 0; n < 60; n++) begin
      a   = 30'($urandom_range(0, 127));
      lat = int'($urandom_range(0, 4));
      h   = model_hit(a);
      fetch(a, lat, d, st, ra, ma, mr);
      total++;
      if (st !== (h ? 0 : lat + 2)) begin
        bad++; $display("FAIL rand_stall addr=%h got=%0d want=%0d", a, st, h ? 0 : lat + 2);
      end
      total++;
      if (d !== word_of(a)) begin bad++; $display("FAIL rand_data addr=%h got=%h want=%h", a, d, word_of(a)); end
      if (!h) begin
        total++;
        if (ma !== a[29:2]) begin bad++; $display("FAIL rand_mem_addr addr=%h got=%h want=%h", a, ma, a[29:2]); end
      end
      model_fill(a);
      $display("random: addr=%h L=%0d hit=%0d stalls=%0d data=%h", a, lat, h, st, d);
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    logic [31:0] d; int st; int ra; logic [27:0] ma; bit mr;
    apply_reset();
    fetch(30'h10, 2, d, st, ra, ma, mr);
    model_fill(30'h10);
    for (int w = 1; w < 4; w++) fetch(30'h10 + 30'(w), 0, d, st, ra, ma, mr);
    @(negedge clk);
    proc_read = 1'b0;
    #1;
    total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL perf_miss got=%0d want=1", miss_cnt); end
    total++; if (hit_cnt !== 32'd4) begin bad++; $display("FAIL perf_hit got=%0d want=4", hit_cnt); end
    $display("perf: hit_cnt=%0d miss_cnt=%0d", hit_cnt, miss_cnt);
  endtask
`endif

  initial begin
    rst_n = 1'b0; proc_read = 1'b0; proc_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
    mem_lines[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    test_reset();
    test_cold_miss();
    test_hit_sweep();
    test_conflict();
    test_latency();
    test_spurious_ready();
    test_reset_mid_refill();
    apply_reset();
    test_random();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
